// File: rtl/fifo_vc_pkg.sv
// Shared definitions for the multi-virtual-channel FIFO bank:
// a clog2 helper for deriving pointer/count/select widths, and the
// per-channel operation encodings formed as {read_ok, write_ok}.
package fifo_vc_pkg;

    localparam logic [1:0] OP_NONE = 2'b00;
    localparam logic [1:0] OP_WR   = 2'b01;
    localparam logic [1:0] OP_RD   = 2'b10;
    localparam logic [1:0] OP_WRRD = 2'b11;

    // Ceiling log2, never below 1 so derived vectors always have a bit.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        if (r == 0) r = 1;
        return r;
    endfunction

endpackage

// File: rtl/fifo_vc_chan.sv
// One virtual-channel FIFO: storage, wrap-around pointers, fill count,
// status flags, sticky overrun/underrun error and optional peak-fill tracker.
// Optional feature macro: FIFO_PEAK_EN (peak_fill tracking; tied to 0 otherwise).
module fifo_vc_chan
    import fifo_vc_pkg::*;
#(
    parameter int BW    = 6,
    parameter int DEPTH = 8,
    parameter int AW    = clog2(DEPTH),
    parameter int CW    = AW + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          wr_en,
    input  logic [BW-1:0] wr_data,
    input  logic          rd_en,
    input  logic [CW-1:0] umbral_bajo,
    input  logic [CW-1:0] umbral_alto,
    input  logic          err_clr,
    output logic [BW-1:0] rd_data,
    output logic          rd_valid,
    output logic [CW-1:0] fill,
    output logic          full,
    output logic          empty,
    output logic          almost_full,
    output logic          almost_empty,
    output logic          error_out,
    output logic [CW-1:0] peak_fill
);

    localparam logic [AW-1:0] LAST_PTR = AW'(DEPTH - 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [BW-1:0] mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic          rd_ok;
    logic          wr_ok;
    logic [1:0]    op;

    // Wrap explicitly at DEPTH-1 so non-power-of-two depths work.
    function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
        return (p == LAST_PTR) ? '0 : p + AW'(1);
    endfunction

    assign full         = (fill == FULL_CNT);
    assign empty        = (fill == '0);
    assign almost_full  = (fill >= umbral_alto);
    assign almost_empty = (fill <= umbral_bajo);

    // A full channel still takes a write when a read frees a slot in the
    // same cycle; an empty channel never forwards a same-cycle write.
    assign rd_ok = rd_en && !empty;
    assign wr_ok = wr_en && (!full || rd_ok);
    assign op    = {rd_ok, wr_ok};

    // Storage is not reset; only pointers and fill define valid contents.
    always_ff @(posedge clk) begin
        if (wr_ok) mem[wptr] <= wr_data;
    end

    // Pointers, occupancy, registered read data and sticky error.
    always_ff @(posedge clk) begin
        if (reset) begin
            wptr      <= '0;
            rptr      <= '0;
            fill      <= '0;
            rd_data   <= '0;
            rd_valid  <= 1'b0;
            error_out <= 1'b0;
        end else begin
            rd_valid <= rd_ok;
            if (rd_ok) begin
                rd_data <= mem[rptr];
                rptr    <= next_ptr(rptr);
            end
            if (wr_ok) wptr <= next_ptr(wptr);
            case (op)
                OP_WR:   fill <= fill + CW'(1);
                OP_RD:   fill <= fill - CW'(1);
                OP_NONE,
                OP_WRRD: fill <= fill;
                default: fill <= fill;
            endcase
            // A new fault outranks a clear arriving in the same cycle.
            if ((wr_en && !wr_ok) || (rd_en && !rd_ok)) error_out <= 1'b1;
            else if (err_clr)                          error_out <= 1'b0;
        end
    end

`ifdef FIFO_PEAK_EN
    // High-water mark of the registered fill, cleared with the error flag.
    always_ff @(posedge clk) begin
        if (reset || err_clr)      peak_fill <= '0;
        else if (fill > peak_fill) peak_fill <= fill;
    end
`else
    assign peak_fill = '0;
`endif

endmodule

// File: rtl/fifo_multi_vc.sv
// Bank of NCH independent virtual-channel FIFOs with one shared,
// channel-selected write port and per-channel read ports.
// Optional feature macro: FIFO_PEAK_EN (per-channel peak fill tracking).
module fifo_multi_vc
    import fifo_vc_pkg::*;
#(
    parameter  int BW    = 6,
    parameter  int DEPTH = 8,
    parameter  int NCH   = 4,
    localparam int AW    = clog2(DEPTH),
    localparam int CW    = AW + 1,
    localparam int CHW   = clog2(NCH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [CHW-1:0]    wr_ch,
    input  logic [BW-1:0]     wr_data,
    input  logic [NCH-1:0]    rd_en,
    input  logic [CW-1:0]     umbral_bajo,
    input  logic [CW-1:0]     umbral_alto,
    input  logic [NCH-1:0]    err_clr,
    output logic [NCH*BW-1:0] rd_data,
    output logic [NCH-1:0]    rd_valid,
    output logic [NCH*CW-1:0] fill,
    output logic [NCH-1:0]    full,
    output logic [NCH-1:0]    empty,
    output logic [NCH-1:0]    almost_full,
    output logic [NCH-1:0]    almost_empty,
    output logic [NCH-1:0]    error_out,
    output logic [NCH*CW-1:0] peak_fill
);

    for (genvar c = 0; c < NCH; c++) begin : g_chan
        logic ch_wr;

        assign ch_wr = wr_en && (wr_ch == CHW'(c));

        fifo_vc_chan #(
            .BW    (BW),
            .DEPTH (DEPTH),
            .AW    (AW),
            .CW    (CW)
        ) u_chan (
            .clk          (clk),
            .reset        (reset),
            .wr_en        (ch_wr),
            .wr_data      (wr_data),
            .rd_en        (rd_en[c]),
            .umbral_bajo  (umbral_bajo),
            .umbral_alto  (umbral_alto),
            .err_clr      (err_clr[c]),
            .rd_data      (rd_data[c*BW +: BW]),
            .rd_valid     (rd_valid[c]),
            .fill         (fill[c*CW +: CW]),
            .full         (full[c]),
            .empty        (empty[c]),
            .almost_full  (almost_full[c]),
            .almost_empty (almost_empty[c]),
            .error_out    (error_out[c]),
            .peak_fill    (peak_fill[c*CW +: CW])
        );
    end

endmodule

// File: tb/tb_fifo_multi_vc.sv
// Testbench for fifo_multi_vc: a queue-based reference model checks every
// output of every channel each cycle, read data goes through a scoreboard,
// and a vector table plus hand sequences pin down the named corner cases.
module tb_fifo_multi_vc;

    localparam int BW    = 6;
    localparam int DEPTH = 8;
    localparam int NCH   = 4;
    localparam int CW    = 4;
    localparam int CHW   = 2;

    logic              clk = 1'b0;
    logic              reset;
    logic              wr_en;
    logic [CHW-1:0]    wr_ch;
    logic [BW-1:0]     wr_data;
    logic [NCH-1:0]    rd_en;
    logic [CW-1:0]     umbral_bajo;
    logic [CW-1:0]     umbral_alto;
    logic [NCH-1:0]    err_clr;
    logic [NCH*BW-1:0] rd_data;
    logic [NCH-1:0]    rd_valid;
    logic [NCH*CW-1:0] fill;
    logic [NCH-1:0]    full;
    logic [NCH-1:0]    empty;
    logic [NCH-1:0]    almost_full;
    logic [NCH-1:0]    almost_empty;
    logic [NCH-1:0]    error_out;
    logic [NCH*CW-1:0] peak_fill;

    always #5 clk = ~clk;

    fifo_multi_vc #(.BW(BW), .DEPTH(DEPTH), .NCH(NCH)) dut (
        .clk          (clk),
        .reset        (reset),
        .wr_en        (wr_en),
        .wr_ch        (wr_ch),
        .wr_data      (wr_data),
        .rd_en        (rd_en),
        .umbral_bajo  (umbral_bajo),
        .umbral_alto  (umbral_alto),
        .err_clr      (err_clr),
        .rd_data      (rd_data),
        .rd_valid     (rd_valid),
        .fill         (fill),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .error_out    (error_out),
        .peak_fill    (peak_fill)
    );

    int tests = 0;
    int fails = 0;

    logic [BW-1:0] mq [NCH][$];   // model contents per channel
    logic [BW-1:0] sb [NCH][$];   // scoreboard of expected read data
    logic          mval  [NCH];
    logic          merr  [NCH];
    int            mpeak [NCH];
    logic [BW-1:0] mlast [NCH];

    typedef struct {
        logic           we;
        int             wch;
        logic [BW-1:0]  wd;
        logic [NCH-1:0] re;
        logic [NCH-1:0] ec;
        int             ch;
        int             exp_fill;
        logic           exp_full;
        logic           exp_err;
    } vec_t;

    vec_t vt [10];

    task automatic chk(input string name, input int c, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s ch%0d: got %0d, expected %0d", name, c, act, exp);
        end
    endtask

    function automatic logic [CW-1:0] fill_of(input int c);
        return fill[c*CW +: CW];
    endfunction

    function automatic logic [BW-1:0] data_of(input int c);
        return rd_data[c*BW +: BW];
    endfunction

    function automatic logic [CW-1:0] peak_of(input int c);
        return peak_fill[c*CW +: CW];
    endfunction

    task automatic check_all();
        logic [BW-1:0] exp_d;
        int            f;
        int            exp_pk;
        for (int c = 0; c < NCH; c++) begin
            f = mq[c].size();
            chk("fill", c, fill_of(c), f);
            chk("full", c, full[c], f == DEPTH);
            chk("empty", c, empty[c], f == 0);
            chk("almost_full", c, almost_full[c], f >= int'(umbral_alto));
            chk("almost_empty", c, almost_empty[c], f <= int'(umbral_bajo));
            chk("error_out", c, error_out[c], merr[c]);
            chk("rd_valid", c, rd_valid[c], mval[c]);
            if (rd_valid[c]) begin
                if (sb[c].size() == 0) begin
                    chk("rd_unexpected", c, 1, 0);
                end else begin
                    exp_d    = sb[c].pop_front();
                    mlast[c] = exp_d;
                    chk("rd_data", c, data_of(c), exp_d);
                end
            end else begin
                chk("rd_hold", c, data_of(c), mlast[c]);
            end
`ifdef FIFO_PEAK_EN
            exp_pk = mpeak[c];
`else
            exp_pk = 0;
`endif
            chk("peak_fill", c, peak_of(c), exp_pk);
        end
    endtask

    // Drive one clock cycle of stimulus, advance the model, then check.
    task automatic cycle(input logic rst, input logic we, input int wch, input logic [BW-1:0] wd,
                         input logic [NCH-1:0] re, input logic [NCH-1:0] ec);
        bit rok;
        bit wok;
        int f;
        reset   = rst;
        wr_en   = we;
        wr_ch   = CHW'(wch);
        wr_data = wd;
        rd_en   = re;
        err_clr = ec;
        for (int c = 0; c < NCH; c++) begin
            if (rst) begin
                mq[c].delete();
                sb[c].delete();
                mval[c]  = 1'b0;
                merr[c]  = 1'b0;
                mpeak[c] = 0;
                mlast[c] = '0;
            end else begin
                f        = mq[c].size();
                mpeak[c] = ec[c] ? 0 : ((f > mpeak[c]) ? f : mpeak[c]);
                rok      = re[c] && (f != 0);
                wok      = we && (wch == c) && ((f != DEPTH) || rok);
                if (rok) sb[c].push_back(mq[c].pop_front());
                if (wok) mq[c].push_back(wd);
                if ((we && (wch == c) && !wok) || (re[c] && !rok)) merr[c] = 1'b1;
                else if (ec[c])                                   merr[c] = 1'b0;
                mval[c] = rok;
            end
        end
        @(posedge clk);
        #1;
        check_all();
        reset   = 1'b0;
        wr_en   = 1'b0;
        rd_en   = '0;
        err_clr = '0;
    endtask

    initial begin
        reset       = 1'b1;
        wr_en       = 1'b0;
        wr_ch       = '0;
        wr_data     = '0;
        rd_en       = '0;
        err_clr     = '0;
        umbral_bajo = 4'd2;
        umbral_alto = 4'd6;

        // Reset state
        cycle(1, 0, 0, 0, 4'b0000, 4'b0000);
        cycle(1, 0, 0, 0, 4'b0000, 4'b0000);
        chk("rst_empty", 0, empty, 4'hF);
        chk("rst_full", 0, full, 4'h0);
        chk("rst_valid", 0, rd_valid, 4'h0);
        chk("rst_error", 0, error_out, 4'h0);
        chk("rst_fill", 0, fill, 16'h0);

        // Fill ch2, overrun it, then clear the error
        for (int i = 0; i < 8; i++) begin
            vt[i].we = 1'b1; vt[i].wch = 2; vt[i].wd = BW'(i + 1); vt[i].re = '0; vt[i].ec = '0;
            vt[i].ch = 2; vt[i].exp_fill = i + 1; vt[i].exp_full = (i == 7); vt[i].exp_err = 1'b0;
        end
        vt[8].we = 1'b1; vt[8].wch = 2; vt[8].wd = 6'h09; vt[8].re = '0; vt[8].ec = '0;
        vt[8].ch = 2; vt[8].exp_fill = 8; vt[8].exp_full = 1'b1; vt[8].exp_err = 1'b1;
        vt[9].we = 1'b0; vt[9].wch = 0; vt[9].wd = '0; vt[9].re = '0; vt[9].ec = 4'b0100;
        vt[9].ch = 2; vt[9].exp_fill = 8; vt[9].exp_full = 1'b1; vt[9].exp_err = 1'b0;
        for (int i = 0; i < 10; i++) begin
            cycle(0, vt[i].we, vt[i].wch, vt[i].wd, vt[i].re, vt[i].ec);
            chk("tbl_fill", vt[i].ch, fill_of(vt[i].ch), vt[i].exp_fill);
            chk("tbl_full", vt[i].ch, full[vt[i].ch], vt[i].exp_full);
            chk("tbl_err", vt[i].ch, error_out[vt[i].ch], vt[i].exp_err);
        end
        chk("other_empty", 0, empty & 4'b1011, 4'b1011);

        // Drain ch2 in order, then exercise pointer wrap
        for (int i = 0; i < 8; i++) begin
            cycle(0, 0, 0, 0, 4'b0100, 4'b0000);
            chk("t3_valid", 2, rd_valid[2], 1'b1);
            chk("t3_data", 2, data_of(2), i + 1);
        end
        cycle(0, 0, 0, 0, 4'b0000, 4'b0000);
        chk("t3_pulse", 2, rd_valid[2], 1'b0);
        for (int i = 0; i < 5; i++) cycle(0, 1, 2, BW'(6'h10 + i), 4'b0000, 4'b0000);
        for (int i = 0; i < 5; i++) cycle(0, 0, 0, 0, 4'b0100, 4'b0000);
        for (int i = 0; i < 6; i++) cycle(0, 1, 2, BW'(6'h20 + i), 4'b0000, 4'b0000);
        for (int i = 0; i < 6; i++) begin
            cycle(0, 0, 0, 0, 4'b0100, 4'b0000);
            chk("wrap_data", 2, data_of(2), 6'h20 + i);
        end

        // Write+read on a full ch1
        for (int i = 0; i < 8; i++) cycle(0, 1, 1, BW'(6'h30 + i), 4'b0000, 4'b0000);
        cycle(0, 1, 1, 6'h3F, 4'b0010, 4'b0000);
        chk("full_wr_fill", 1, fill_of(1), 8);
        chk("full_wr_data", 1, data_of(1), 6'h30);
        chk("full_wr_err", 1, error_out[1], 1'b0);
        for (int i = 0; i < 8; i++) cycle(0, 0, 0, 0, 4'b0010, 4'b0000);
        chk("full_wr_last", 1, data_of(1), 6'h3F);

        // Write+read on an empty ch0
        cycle(0, 1, 0, 6'h15, 4'b0001, 4'b0000);
        chk("empty_wr_fill", 0, fill_of(0), 1);
        chk("empty_wr_valid", 0, rd_valid[0], 1'b0);
        chk("empty_wr_err", 0, error_out[0], 1'b1);
        // Underrun and clear together on ch3: the set wins
        cycle(0, 0, 0, 0, 4'b1000, 4'b1000);
        chk("set_wins", 3, error_out[3], 1'b1);
        cycle(0, 0, 0, 0, 4'b0000, 4'b1111);
        chk("clr_all", 0, error_out, 4'h0);
        cycle(0, 0, 0, 0, 4'b0001, 4'b0000);
        chk("empty_wr_data", 0, data_of(0), 6'h15);

        // Watermarks on ch3 while filling 0..7
        for (int i = 0; i < 7; i++) begin
            cycle(0, 1, 3, BW'(6'h01 + i), 4'b0000, 4'b0000);
            chk("wm_ae", 3, almost_empty[3], (i + 1) <= 2);
            chk("wm_af", 3, almost_full[3], (i + 1) >= 6);
        end
        umbral_alto = 4'd0;
        umbral_bajo = 4'd8;
        cycle(0, 0, 0, 0, 4'b0000, 4'b0000);
        chk("af_forced", 0, almost_full, 4'hF);
        chk("ae_forced", 0, almost_empty, 4'hF);
        umbral_alto = 4'd6;
        umbral_bajo = 4'd2;
        for (int i = 0; i < 7; i++) cycle(0, 0, 0, 0, 4'b1000, 4'b0000);
        for (int c = 0; c < NCH; c++) chk("sb_drained", c, sb[c].size(), 0);

        // Reset mid-burst with fill=5 on ch0
        cycle(1, 0, 0, 0, 4'b0000, 4'b0000);
        for (int i = 0; i < 5; i++) cycle(0, 1, 0, BW'(6'h2A + i), 4'b0000, 4'b0000);
        cycle(0, 0, 0, 0, 4'b0000, 4'b0000);
        chk("pre_rst_fill", 0, fill_of(0), 5);
`ifdef FIFO_PEAK_EN
        chk("pre_rst_peak", 0, peak_of(0), 5);
`endif
        cycle(1, 1, 0, 6'h3A, 4'b0001, 4'b0000);
        chk("post_rst_fill", 0, fill_of(0), 0);
        chk("post_rst_empty", 0, empty[0], 1'b1);
        chk("post_rst_valid", 0, rd_valid[0], 1'b0);
        chk("post_rst_peak", 0, peak_of(0), 0);
        cycle(0, 1, 0, 6'h3B, 4'b0000, 4'b0000);
        chk("post_rst_run", 0, fill_of(0), 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
